alu_iter_exec: RTL and testbench
================================

// Module: alu_iter_exec
// PURPOSE
//   Multi-cycle ALU execute unit. It consumes the 5-bit ALUCtrl/Sign encoding produced by the ALU control decoder.
//   Logic and arithmetic ops finish in one cycle; shifts run iteratively at one bit per cycle.
//   Valid/ready handshakes on both sides let the execute unit of the multi-cycle CPU stall on long shifts.
// PARAMETERS
//   WIDTH    32              datapath width (result, in1, in2)
//   SHAMT_W  $clog2(WIDTH)   shift-amount width; shamt = in1[SHAMT_W-1:0]
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous reset, active-low (0 = reset)
//   in_valid   in   1      operation request valid
//   in_ready   out  1      unit can accept a request this cycle
//   ALUCtrl    in   5      op code: ADD 00000, OR 00001, AND 00010, SUB 00110, SLT 00111,
//                          NOR 01100, XOR 01101, SRL 10000, SRA 11000, SLL 11001
//   Sign       in   1      1 = signed SLT compare, 0 = unsigned compare
//   in1        in   WIDTH  operand A; shift amount for SRL/SRA/SLL
//   in2        in   WIDTH  operand B; value to shift for SRL/SRA/SLL
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  registered result
//   zero       out  1      registered (result == 0)
// BEHAVIOUR
//   Reset (reset=0, async):
//     state=IDLE; out_valid=0; result=0; zero=0; shift counter=0. in_ready=1 once reset=1.
//   States: IDLE, SHIFT, DONE.
//     in_ready = (state==IDLE) | (state==DONE & out_ready).
//     out_valid = (state==DONE).
//   Accept: happens on any edge with in_valid & in_ready. ALUCtrl, Sign, in1, in2 are captured on that edge only.
//     Non-shift op, or shift with shamt==0: result computed and registered on the accept edge -> DONE.
//       Latency is 1 cycle.
//     Shift with shamt=k>0: in2 is loaded into the shift register, counter=k -> SHIFT.
//       Each SHIFT edge shifts one bit and decrements the counter. The edge that brings the counter to 0 -> DONE.
//       out_valid rises k+1 cycles after accept.
//     Shift fill: SRL fills with 0, SLL fills with 0, SRA fills with the captured in2[WIDTH-1].
//   DONE: result and zero are held stable while out_ready=0.
//     DONE & out_ready & ~in_valid -> IDLE.
//     DONE & out_ready & in_valid -> back-to-back accept; the next state follows the accept rules above.
//   SHIFT: in_ready=0. in_valid is ignored, and no input is sampled.
//   Arithmetic:
//     ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
//     SLT gives result = {WIDTH-1 zeros, lt}.
//       Sign=1: lt = $signed(in1) < $signed(in2).
//       Sign=0: lt = in1 < in2 (unsigned).
//     Undefined ALUCtrl codes execute as ADD.
//   zero is computed from the final result and updates on the same edge as result.
//   Reset mid-operation aborts any SHIFT/DONE content. No result is emitted for the aborted op.
// TESTING
//   1. ADD in1=5, in2=7, out_ready=1 -> next cycle out_valid=1, result=12, zero=0; then IDLE, in_ready=1.
//   2. SUB in1=9, in2=9 -> result=0, zero=1. SLT in1=32'hFFFFFFFF, in2=1:
//      Sign=1 -> result=1; Sign=0 -> result=0.
//   3. SRA in1=4, in2=32'h80000000 -> in_ready=0 for 4 cycles, out_valid 5 cycles after accept, result=32'hF8000000.
//      Same operands with SRL -> result=32'h08000000. SLL in1=0, in2=32'h1234 -> 1-cycle latency, result=32'h1234.
//   4. Backpressure: ADD accepted, out_ready=0 for 3 cycles while in_valid=1 with new operands ->
//      result stays constant, in_ready=0. Then out_ready=1 -> same-edge accept of the next op, with no idle gap.
//   5. SLL in1=31, in2=1; assert reset=0 at cycle 10 of the shift -> out_valid=0, result=0 immediately.
//      After release, ADD 2+3 -> result=5 with 1-cycle latency.
//   6. Undefined ALUCtrl=5'b00011, in1=10, in2=20 -> result=30.

Source files
------------

// File: rtl/alu_iter_exec.sv
// rtl/alu_iter_exec.sv - multi-cycle ALU execute unit with one-bit-per-cycle shifter
//
// Logic and arithmetic ops complete on the accept edge. Shifts walk one bit
// per cycle through a private shift register. Valid/ready handshakes on the
// request and result sides let the surrounding pipeline stall on long shifts.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active-low
//   in_valid   request valid
//   in_ready   unit can accept a request this cycle
//   ALUCtrl    5-bit op code (ADD/OR/AND/SUB/SLT/NOR/XOR/SRL/SRA/SLL)
//   Sign       1 = signed SLT compare, 0 = unsigned
//   in1        operand A, shift amount for shifts (low SHAMT_W bits)
//   in2        operand B, value to shift for shifts
//   out_valid  result valid
//   out_ready  consumer takes the result
//   result     registered result
//   zero       registered (result == 0)

module alu_iter_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUCtrl,
    input  logic             Sign,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOR = 5'b01100;
    localparam logic [4:0] OP_XOR = 5'b01101;
    localparam logic [4:0] OP_SRL = 5'b10000;
    localparam logic [4:0] OP_SRA = 5'b11000;
    localparam logic [4:0] OP_SLL = 5'b11001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               shl_q;   // direction of the running shift: 1 = left
    logic               fill_q;  // bit shifted in from the top on right shifts

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               accept;
    logic               lt;
    logic [WIDTH-1:0]   alu_d;
    logic [WIDTH-1:0]   shift_d;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    assign accept   = in_valid & in_ready;
    assign shamt    = in1[SHAMT_W-1:0];
    assign is_shift = (ALUCtrl == OP_SRL) | (ALUCtrl == OP_SRA) | (ALUCtrl == OP_SLL);

    always_comb begin
        lt = 1'b0;
        if (Sign) begin
            lt = $signed(in1) < $signed(in2);
        end else begin
            lt = in1 < in2;
        end
    end

    // Single-cycle result. A shift only reaches this path with a zero amount,
    // in which case the value passes through untouched.
    always_comb begin
        alu_d = in1 + in2;
        case (ALUCtrl)
            OP_ADD:  alu_d = in1 + in2;
            OP_OR:   alu_d = in1 | in2;
            OP_AND:  alu_d = in1 & in2;
            OP_SUB:  alu_d = in1 - in2;
            OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, lt};
            OP_NOR:  alu_d = ~(in1 | in2);
            OP_XOR:  alu_d = in1 ^ in2;
            OP_SRL:  alu_d = in2;
            OP_SRA:  alu_d = in2;
            OP_SLL:  alu_d = in2;
            default: alu_d = in1 + in2;
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        shift_d = shreg_q;
        if (shl_q) begin
            shift_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_d = {fill_q, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            shl_q    <= 1'b0;
            fill_q   <= 1'b0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    // Inputs are ignored here; in_ready is low.
                    shreg_q <= shift_d;
                    cnt_q   <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q <= shift_d;
                        zero_q   <= (shift_d == '0);
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE share the accept path so a DONE with
                    // out_ready can take the next op on the same edge.
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            shreg_q <= in2;
                            cnt_q   <= shamt;
                            shl_q   <= (ALUCtrl == OP_SLL);
                            fill_q  <= (ALUCtrl == OP_SRA) & in2[WIDTH-1];
                            state_q <= S_SHIFT;
                        end else begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            state_q  <= S_DONE;
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter_exec.sv
// tb/tb_alu_iter_exec.sv - scoreboard bench for alu_iter_exec

module tb_alu_iter_exec;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ALUCtrl;
    logic        Sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    alu_iter_exec #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUCtrl   (ALUCtrl),
        .Sign      (Sign),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          exp_cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   cur_checked = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: plain operator-level arithmetic from the op table.
    function automatic logic [31:0] model(input logic [4:0] c, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        logic       lt;
        sh = a[4:0];
        lt = s ? ($signed(a) < $signed(b)) : (a < b);
        case (c)
            5'b00000: return a + b;
            5'b00001: return a | b;
            5'b00010: return a & b;
            5'b00110: return a - b;
            5'b00111: return {31'b0, lt};
            5'b01100: return ~(a | b);
            5'b01101: return a ^ b;
            5'b10000: return b >> sh;
            5'b11000: return 32'($signed(b) >>> sh);
            5'b11001: return b << sh;
            default:  return a + b;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] c, input logic [31:0] a);
        bit shift_op;
        shift_op = (c == 5'b10000) || (c == 5'b11000) || (c == 5'b11001);
        if (shift_op && a[4:0] != 0) return int'(a[4:0]) + 1;
        return 1;
    endfunction

    // Hold a request until accepted, then queue its expected result.
    task automatic drive(input logic [4:0] c, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input bit rnd_rdy, input bit use_model,
                         input logic [31:0] xres, input int xlat);
        bit   done;
        exp_t e;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            out_ready = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
            ALUCtrl   = c;
            Sign      = s;
            in1       = a;
            in2       = b;
            in_valid  = 1'b1;
            #1;
            if (in_ready) begin
                e.res     = use_model ? model(c, s, a, b) : xres;
                e.lat     = use_model ? model_lat(c, a) : xlat;
                e.exp_cyc = cyc + e.lat;
                q.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: op %b not accepted within 200 cycles", c);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            in1       = $urandom;
            in2       = $urandom;
        end
    endtask

    // Monitor: compares each result on its first valid cycle and checks it
    // stays put until the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (q.size() > 0 && !cur_checked && cyc == q[0].exp_cyc) begin
                    chk("out_valid_on_time", {31'b0, out_valid}, 32'd1);
                    chk("result", result, q[0].res);
                    chk("zero", {31'b0, zero}, {31'b0, (q[0].res == 32'd0)});
                    cur_checked = 1;
                end else if (out_valid && cur_checked) begin
                    chk("result_hold", result, q[0].res);
                end else if (out_valid) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_valid_unexpected: got 1 expected 0 (cycle %0d, pending %0d)",
                             cyc, q.size());
                end
                if (out_valid && out_ready && cur_checked) begin
                    void'(q.pop_front());
                    cur_checked = 0;
                end
            end
        end
    end

    localparam logic [4:0] C_ADD = 5'b00000, C_SUB = 5'b00110, C_SLT = 5'b00111,
                           C_SRL = 5'b10000, C_SRA = 5'b11000, C_SLL = 5'b11001;

    logic [4:0] codes [12];
    int         low_cnt;

    initial begin
        codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111, 5'b01100,
                  5'b01101, 5'b10000, 5'b11000, 5'b11001, 5'b00011, 5'b10101};
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALUCtrl   = '0;
        Sign      = 1'b0;
        in1       = '0;
        in2       = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", {31'b0, zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // ADD, then back to idle
        drive(C_ADD, 1'b0, 32'd5, 32'd7, 1'b0, 1'b0, 32'd12, 1);
        idle(2);
        #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // SUB to zero, SLT signed / unsigned
        drive(C_SUB, 1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0, 1);
        drive(C_SLT, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd1, 1);
        drive(C_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1);
        idle(2);

        // SRA by 4: in_ready low for exactly the 4 shift cycles
        drive(C_SRA, 1'b0, 32'd4, 32'h8000_0000, 1'b0, 1'b0, 32'hF800_0000, 5);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (in_ready) break;
            low_cnt++;
        end
        chk("sra_in_ready_low_cycles", low_cnt, 32'd4);
        drive(C_SRL, 1'b0, 32'd4, 32'h8000_0000, 1'b0, 1'b0, 32'h0800_0000, 5);
        drive(C_SLL, 1'b0, 32'd0, 32'h1234, 1'b0, 1'b0, 32'h1234, 1);
        idle(3);

        // Backpressure with a new op waiting, then same-edge accept
        drive(C_ADD, 1'b0, 32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            ALUCtrl   = C_ADD;
            in1       = 32'd40;
            in2       = 32'd2;
            in_valid  = 1'b1;
            #1;
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        drive(C_ADD, 1'b0, 32'd40, 32'd2, 1'b0, 1'b0, 32'd42, 1);
        idle(3);

        // Reset during a long shift
        drive(C_SLL, 1'b0, 32'd31, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 32);
        idle(10);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midreset_result", result, 32'd0);
        q.delete();
        cur_checked = 0;
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        drive(C_ADD, 1'b0, 32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 1);
        idle(2);

        // Undefined op executes as ADD
        drive(5'b00011, 1'b0, 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1);
        idle(2);

        // Randomized traffic with random backpressure and gaps
        for (int n = 0; n < 150; n++) begin
            logic [4:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = codes[$urandom_range(11)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(3) == 0) a[4:0] = 5'd0;
            if ($urandom_range(5) == 0) b = a;
            drive(c, 1'($urandom_range(1)), a, b, 1'b1, 1'b1, 32'd0, 0);
            if ($urandom_range(2) == 0) idle($urandom_range(3));
        end
        idle(60);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
